// File: rtl/matmul_seq_ctrl.sv
// Serial-load sequencer around a combinational 4x4 x 4x2 matrix multiplier.
// Optional weight-stationary A reuse is compiled in with `define MATSEQ_KEEP_A_EN.

// One output lane: 4-term dot product of 4-bit unsigned operands, 10-bit result.
module matseq_dot4 (
  input  logic [3:0][3:0] i_row,
  input  logic [3:0][3:0] i_col,
  output logic [9:0]      o_sum
);
  logic [3:0][7:0] w_p;

  genvar k;
  for (k = 0; k < 4; k++) begin : g_prod
    assign w_p[k] = {4'b0, i_row[k]} * {4'b0, i_col[k]};
  end

  // 4 x 225 = 900 fits in 10 bits, so no carry is lost.
  assign o_sum = {2'b0, w_p[0]} + {2'b0, w_p[1]} + {2'b0, w_p[2]} + {2'b0, w_p[3]};
endmodule

// Combinational 4x4 (A) x 4x2 (B) product; S(2i+j) = sum_k A(4i+k) * B(2k+j).
module Mul4x4_4x2matrix (
  input  logic [15:0][3:0] i_a,
  input  logic [7:0][3:0]  i_b,
  output logic [7:0][9:0]  o_s
);
  genvar g, k;
  for (g = 0; g < 8; g++) begin : g_lane
    logic [3:0][3:0] w_col;
    for (k = 0; k < 4; k++) begin : g_col
      assign w_col[k] = i_b[2*k + (g % 2)];
    end
    matseq_dot4 u_dot (
      .i_row (i_a[(4*(g/2)+3) -: 4]),
      .i_col (w_col),
      .o_sum (o_s[g])
    );
  end
endmodule

module matmul_seq_ctrl (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_in_valid,
  input  logic [3:0] i_in_data,
  output logic       o_in_ready,
  input  logic       i_a_keep,
  output logic       o_out_valid,
  output logic [9:0] o_out_data,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_done
);
  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_COMPUTE, S_OUTPUT} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [2:0]       r_idx;
  logic [15:0][3:0] r_a;
  logic [7:0][3:0]  r_b;
  logic [7:0][9:0]  r_res;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [9:0]       r_out_data;
  logic             r_busy;
  logic             r_done;

  logic [7:0][9:0]  w_s;
  logic             w_keep;
  logic             w_in_hs;

`ifdef MATSEQ_KEEP_A_EN
  assign w_keep = i_a_keep;
`else
  logic w_unused_a_keep;
  assign w_unused_a_keep = i_a_keep;
  assign w_keep          = 1'b0;
`endif

  // Multiplier sees only operand registers, which move only on input handshakes.
  Mul4x4_4x2matrix u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_s (w_s)
  );

  assign w_in_hs = i_in_valid && r_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_LOAD_A;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_LOAD_A: begin
          r_in_ready <= 1'b1;
          if (w_in_hs) begin
            r_a[r_cnt] <= i_in_data;
            r_busy     <= 1'b1;
            if (r_cnt == 4'd15) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_LOAD_B: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
          if (w_in_hs) begin
            r_b[r_cnt[2:0]] <= i_in_data;
            if (r_cnt == 4'd7) begin
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_COMPUTE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_COMPUTE: begin
          r_res       <= w_s;
          r_out_data  <= w_s[0];
          r_out_valid <= 1'b1;
          r_state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (i_out_ready) begin
            if (r_idx == 3'd7) begin
              r_idx       <= '0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_done      <= 1'b1;
              r_in_ready  <= 1'b1;
              // Kept A resumes at LOAD_B, which still counts as busy.
              r_busy      <= w_keep;
              r_state     <= w_keep ? S_LOAD_B : S_LOAD_A;
            end else begin
              r_idx      <= r_idx + 3'd1;
              r_out_data <= r_res[r_idx + 3'd1];
            end
          end
        end
        default: r_state <= S_LOAD_A;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: directed jobs with hand-computed results.
module tb_matmul_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_in_valid;
  logic [3:0] i_in_data;
  logic       o_in_ready;
  logic       i_a_keep;
  logic       o_out_valid;
  logic [9:0] o_out_data;
  logic       i_out_ready;
  logic       o_busy;
  logic       o_done;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int sb[$];

  matmul_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .i_a_keep    (i_a_keep),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .i_out_ready (i_out_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    if (!rst && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_out: got %0d, expected no output (t=%0t)", o_out_data, $time);
      end else begin
        chk("out_data", int'(o_out_data), sb.pop_front());
      end
      beat_cnt++;
    end
    if (!rst && o_done) done_cnt++;
  end

  // All drive tasks start and end 1ns after a rising edge.
  task automatic send(input int d);
    int n = 0;
    i_in_valid = 1'b1;
    i_in_data  = 4'(d);
    forever begin
      @(negedge clk);
      if (o_in_ready) begin
        @(posedge clk); #1;
        break;
      end
      if (++n > 200) begin
        chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        break;
      end
    end
    i_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_job(input int a[16], input int b[8], input int e[8], input bit gaps);
    beat_cnt = 0;
    for (int i = 0; i < 8; i++) sb.push_back(e[i]);
    for (int i = 0; i < 16; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(a[i]);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(b[i]);
    end
  endtask

  // Called right after the last input handshake (cycle N): COMPUTE at N+1, S0 at N+2.
  task automatic check_latency();
    @(negedge clk);
    chk("compute_valid", int'(o_out_valid), 0);
    chk("compute_in_ready", int'(o_in_ready), 0);
    @(negedge clk);
    chk("first_out_valid", int'(o_out_valid), 1);
  endtask

  // From the negedge of N+2, wait for done; exp_n < 0 skips the exact timing check.
  task automatic finish_job(input int exp_n, input int exp_busy);
    int n = 0;
    bit got = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (o_done) begin got = 1; break; end
    end
    chk("done_seen", int'(got), 1);
    if (exp_n >= 0) chk("done_cycle", n, exp_n);
    chk("done_in_ready", int'(o_in_ready), 1);
    chk("done_busy", int'(o_busy), exp_busy);
    chk("beats", beat_cnt, 8);
    chk("drained", sb.size(), 0);
    @(negedge clk);
    chk("done_pulse", int'(o_done), 0);
    @(posedge clk); #1;
  endtask

  int a_basic[16], b_basic[8], e_basic[8];
  int a_v[16], b_v[8], e_v[8];

  initial begin
    rst = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_a_keep = 1'b0; i_out_ready = 1'b1;
    a_basic = '{1,2,2,2, 2,1,2,3, 3,1,1,2, 4,2,1,1};
    b_basic = '{6,5, 1,3, 3,2, 7,3};
    e_basic = '{28,21, 40,26, 36,26, 36,31};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(o_in_ready), 0);
    chk("rst_out_valid", int'(o_out_valid), 0);
    chk("rst_out_data", int'(o_out_data), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(o_in_ready), 1);
    chk("post_rst_busy", int'(o_busy), 0);
    @(posedge clk); #1;

    // Basic job, back-to-back, out_ready high
    load_job(a_basic, b_basic, e_basic, 1'b0);
    check_latency();
    finish_job(8, 0);

    // Max values: 4*15*15 = 900
    foreach (a_v[i]) a_v[i] = 15;
    foreach (b_v[i]) b_v[i] = 15;
    foreach (e_v[i]) e_v[i] = 900;
    load_job(a_v, b_v, e_v, 1'b0);
    check_latency();
    finish_job(8, 0);

    // Input gaps plus a 3-cycle output stall at S3; stray in_valid during OUTPUT
    load_job(a_basic, b_basic, e_basic, 1'b1);
    check_latency();
    repeat (3) begin @(posedge clk); #1; end
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = 4'd9;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", int'(o_out_data), 26);
      chk("stall_valid", int'(o_out_valid), 1);
      chk("stall_in_ready", int'(o_in_ready), 0);
    end
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    i_in_valid  = 1'b0;
    finish_job(-1, 0);

    // Reset after 10 A elements, then A=2, B=1 -> 8
    for (int i = 0; i < 10; i++) send(7);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_in_ready", int'(o_in_ready), 0);
    chk("midrst_busy", int'(o_busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    foreach (a_v[i]) a_v[i] = 2;
    foreach (b_v[i]) b_v[i] = 1;
    foreach (e_v[i]) e_v[i] = 8;
    load_job(a_v, b_v, e_v, 1'b0);
    check_latency();
    finish_job(8, 0);

    // Keep-A sequence: A=15, B=1 with a_keep=1
    i_a_keep = 1'b1;
    foreach (a_v[i]) a_v[i] = 15;
    foreach (e_v[i]) e_v[i] = 60;
    load_job(a_v, b_v, e_v, 1'b0);
    check_latency();
`ifdef MATSEQ_KEEP_A_EN
    finish_job(8, 1);
    i_a_keep = 1'b0;
    beat_cnt = 0;
    for (int i = 0; i < 8; i++) sb.push_back(120);
    for (int i = 0; i < 8; i++) send(2);
    check_latency();
    finish_job(8, 0);
`else
    finish_job(8, 0);
    i_a_keep = 1'b0;
    beat_cnt = 0;
    for (int i = 0; i < 4; i++) sb.push_back(8);
    for (int i = 0; i < 4; i++) sb.push_back(12);
    for (int i = 0; i < 8; i++) send(2);
    repeat (3) begin
      @(negedge clk);
      chk("nokeep_no_out", int'(o_out_valid), 0);
      chk("nokeep_in_ready", int'(o_in_ready), 1);
      chk("nokeep_busy", int'(o_busy), 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) send(3);
    for (int i = 0; i < 8; i++) send(1);
    check_latency();
    finish_job(8, 0);
`endif

    chk("done_count", done_cnt, 6);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
